// File: rtl/seq_mac_if.sv
// Operand/result handshake bundle for seq_mac: start with a, b, c in; busy, done, result, ovf out.
interface seq_mac_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   c;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 ovf;

  modport master (
    output start, a, b, c,
    input  busy, done, result, ovf
  );

  modport slave (
    input  start, a, b, c,
    output busy, done, result, ovf
  );
endinterface

// File: rtl/seq_mac.sv
// Shift-add multiply-accumulate: result = a*b + c, one multiplier bit per clock.
// Optional SEQ_MAC_EARLY_EXIT_EN ends the run once no multiplier 1-bits remain.
module seq_mac #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  seq_mac_if.slave  bus
);
  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [AW:0]        acc_q, acc_d;
  logic [AW-1:0]      mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic               done_q, done_d;
  logic [AW-1:0]      result_q, result_d;
  logic               ovf_q, ovf_d;

  logic               add_en;
  logic [AW:0]        sum;
  logic [AW:0]        acc_step;
  logic               sticky_step;
  logic [WIDTH-1:0]   mplier_shift;
  logic               last;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;

    add_en       = mplier_q[0];
    sum          = {1'b0, acc_q[AW-1:0]} + {1'b0, mcand_q};
    acc_step     = add_en ? sum : acc_q;
    sticky_step  = sticky_q | (add_en & sum[AW]);
    mplier_shift = mplier_q >> 1;
    last         = (cnt_q == CW'(WIDTH - 1));
`ifdef SEQ_MAC_EARLY_EXIT_EN
    last         = last | (mplier_shift == '0);
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d    = {1'b0, bus.c};
          mcand_d  = AW'(bus.a);
          mplier_d = bus.b;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + CW'(1);
        sticky_d = sticky_step;
        // The final add lands in result directly, so done needs no extra cycle.
        if (last) begin
          result_d = acc_step[AW-1:0];
          ovf_d    = sticky_step | acc_step[AW];
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_seq_mac.sv
// Directed bench for seq_mac (WIDTH=8): vector table plus reset-abort, hold and back-to-back sequences.
module tb_seq_mac;
  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  seq_mac_if #(.WIDTH(W)) bus ();

  seq_mac #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] c;
    logic [2*W-1:0] res;
    logic           ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycles from the accept edge to the done cycle.
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SEQ_MAC_EARLY_EXIT_EN
    int r;
    r = 1;
    for (int i = 0; i < int'(W); i++) if (b[i]) r = i + 1;
    return r + 1;
`else
    return int'(W) + 1;
`endif
  endfunction

  // Called at a negedge of cycle T+1; walks to the done cycle and checks it.
  task automatic walk_to_done(input string nm, input int lat,
                              input logic [2*W-1:0] er, input logic eo);
    for (int k = 1; k <= lat; k++) begin
      if (k < lat) begin
        chk({nm, " busy/done run"}, {30'd0, bus.busy, bus.done}, 32'd2);
        @(negedge clk);
      end else begin
        chk({nm, " busy/done at done"}, {30'd0, bus.busy, bus.done}, 32'd1);
        chk({nm, " result"}, {16'd0, bus.result}, {16'd0, er});
        chk({nm, " ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
      end
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic [2*W-1:0] c_i, input logic [2*W-1:0] er, input logic eo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a_i;
    bus.b = b_i;
    bus.c = c_i;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.c = 16'($urandom);
    walk_to_done(nm, exp_lat(b_i), er, eo);
    @(negedge clk);
    chk({nm, " done drops"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen_done;
    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  c: 16'd7,     res: 16'd150,   ovf: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd255, c: 16'd0,     res: 16'd65025, ovf: 1'b0};
    vecs[2] = '{a: 8'd255, b: 8'd255, c: 16'd511,   res: 16'd0,     ovf: 1'b1};
    vecs[3] = '{a: 8'd0,   b: 8'd200, c: 16'd1234,  res: 16'd1234,  ovf: 1'b0};
    vecs[4] = '{a: 8'd9,   b: 8'd0,   c: 16'd65535, res: 16'd65535, ovf: 1'b0};
    vecs[5] = '{a: 8'd200, b: 8'd100, c: 16'd5000,  res: 16'd25000, ovf: 1'b0};
    vecs[6] = '{a: 8'd1,   b: 8'd1,   c: 16'd65535, res: 16'd0,     ovf: 1'b1};
    vecs[7] = '{a: 8'd128, b: 8'd255, c: 16'd32640, res: 16'd65280, ovf: 1'b0};
    vecs[8] = '{a: 8'd255, b: 8'd1,   c: 16'd65535, res: 16'd254,   ovf: 1'b1};
    vecs[9] = '{a: 8'd3,   b: 8'd128, c: 16'd100,   res: 16'd484,   ovf: 1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset result", {16'd0, bus.result}, 32'd0);
    chk("reset ovf", {31'd0, bus.ovf}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].res, vecs[i].ovf);
    end

    // Result holds long after done.
    run_op("hold", 8'd13, 8'd11, 16'd7, 16'd150, 1'b0);
    repeat (10) @(negedge clk);
    chk("hold result late", {16'd0, bus.result}, 32'd150);
    chk("hold idle busy", {31'd0, bus.busy}, 32'd0);

    // Reset in cycle T+4 aborts the run.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'd77;
    bus.b = 8'd255;
    bus.c = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    chk("abort result", {16'd0, bus.result}, 32'd0);
    chk("abort ovf", {31'd0, bus.ovf}, 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    chk("abort no done", {31'd0, seen_done}, 32'd0);

    // start held through busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'd3;
    bus.b = 8'd5;
    bus.c = 16'd0;
    @(negedge clk);
    bus.a = 8'd100;
    walk_to_done("b2b first", exp_lat(8'd5), 16'd15, 1'b0);
    bus.a = 8'd6;
    bus.b = 8'd7;
    bus.c = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    walk_to_done("b2b second", exp_lat(8'd7), 16'd43, 1'b0);
    @(negedge clk);
    chk("b2b done drops", {31'd0, bus.done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
